// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared types and constants for the sprite transform buffer.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    typedef struct packed {
        logic       mirror;
        logic [1:0] rot;
    } orient_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } sb_state_t;

    localparam logic [1:0] ROT_0   = 2'd0;
    localparam logic [1:0] ROT_90  = 2'd1;
    localparam logic [1:0] ROT_180 = 2'd2;
    localparam logic [1:0] ROT_270 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sprite_xform_buffer_addr_map.sv
`default_nettype none
// ============================================================================
// Module   : sprite_addr_map
// Purpose  : Maps a raster-order output index to its source pixel address.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_addr_map
    import sprite_pkg::*;
#(
    parameter int SIDE = 8
) (
    input  logic [2*$clog2(SIDE)-1:0] rd_idx_i,
    input  orient_t                   orient_i,
    output logic [2*$clog2(SIDE)-1:0] src_addr_o
);

    localparam int L  = $clog2(SIDE);
    localparam int IW = 2 * L;
    localparam logic [L-1:0] C_MAX = '1;

    logic [L-1:0] row;
    logic [L-1:0] col;
    logic [L-1:0] src_row;
    logic [L-1:0] src_col;

    // Field-width subtraction from C_MAX keeps every term inside 0..N-1.
    always_comb begin
        row     = rd_idx_i[IW-1:L];
        col     = rd_idx_i[L-1:0];
        src_row = row;
        src_col = col;
        case (orient_i.rot)
            ROT_0: begin
                src_row = row;
                src_col = col;
            end
            ROT_90: begin
                src_row = C_MAX - col;
                src_col = row;
            end
            ROT_180: begin
                src_row = C_MAX - row;
                src_col = C_MAX - col;
            end
            ROT_270: begin
                src_row = col;
                src_col = C_MAX - row;
            end
            default: begin
                src_row = row;
                src_col = col;
            end
        endcase
        if (orient_i.mirror) begin
            src_col = C_MAX - src_col;
        end
        src_addr_o = {src_row, src_col};
    end

endmodule
`default_nettype wire

// File: rtl/sprite_xform_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sprite_xform_buffer
// Purpose  : Stages one square sprite and replays it in one of 8 orientations.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_xform_buffer
    import sprite_pkg::*;
#(
    parameter int SIDE = 8,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write,
    input  logic          i_valid,
    input  logic [CW-1:0] i_r,
    input  logic [CW-1:0] i_g,
    input  logic [CW-1:0] i_b,
    input  logic          read,
    input  logic          set_orientation,
    input  logic [2:0]    orientation,
    input  logic          set_key,
    input  logic          key_en,
    input  logic [CW-1:0] key_r,
    input  logic [CW-1:0] key_g,
    input  logic [CW-1:0] key_b,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [CW-1:0] o_r,
    output logic [CW-1:0] o_g,
    output logic [CW-1:0] o_b,
    output logic          o_last,
    output logic          o_transparent,
    output logic          busy
);

    localparam int IW    = 2 * $clog2(SIDE);
    localparam int DEPTH = SIDE * SIDE;
    localparam int PW    = 3 * CW;
    localparam logic [IW-1:0] LAST_IDX = '1;

    sb_state_t       state_q, state_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    orient_t         orient_q, orient_d;
    orient_t         snap_q, snap_d;
    logic            key_en_q, key_en_d;
    logic [PW-1:0]   key_q, key_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic            mem_we;
    logic [IW-1:0]   src_addr;
    logic [PW-1:0]   mem_q [DEPTH];

    sprite_addr_map #(
        .SIDE (SIDE)
    ) u_addr_map (
        .rd_idx_i   (rd_idx_q),
        .orient_i   (snap_q),
        .src_addr_o (src_addr)
    );

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        snap_d   = snap_q;
        valid_d  = valid_q;
        last_d   = last_q;
        pix_d    = pix_q;
        mem_we   = 1'b0;
        orient_d = set_orientation ? orient_t'(orientation) : orient_q;
        key_en_d = set_key ? key_en : key_en_q;
        key_d    = set_key ? {key_r, key_g, key_b} : key_q;
        case (state_q)
            IDLE: begin
                if (write) begin
                    state_d  = LOAD;
                    wr_idx_d = '0;
                end else if (read) begin
                    state_d  = READ;
                    rd_idx_d = '0;
                    snap_d   = orient_q;
                end
            end
            LOAD: begin
                if (i_valid) begin
                    mem_we   = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                // Refill the output register whenever it is empty or being drained.
                if (valid_q && o_ready && last_q) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (!valid_q || o_ready) begin
                    valid_d  = 1'b1;
                    pix_d    = mem_q[src_addr];
                    last_d   = (rd_idx_q == LAST_IDX);
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            orient_q <= '0;
            snap_q   <= '0;
            key_en_q <= 1'b0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            orient_q <= orient_d;
            snap_q   <= snap_d;
            key_en_q <= key_en_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            pix_q    <= pix_d;
        end
    end

    // Pixel storage deliberately survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_idx_q] <= {i_r, i_g, i_b};
        end
    end

    assign o_valid       = valid_q;
    assign o_last        = last_q;
    assign o_r           = pix_q[PW-1:2*CW];
    assign o_g           = pix_q[2*CW-1:CW];
    assign o_b           = pix_q[CW-1:0];
    assign o_transparent = valid_q & key_en_q & (pix_q == key_q);
    assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_xform_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_xform_buffer
// Purpose  : Self-checking bench for sprite_xform_buffer (SIDE=8, CW=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_xform_buffer;

    localparam int N  = 8;
    localparam int NN = N * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write = 1'b0, i_valid = 1'b0, read = 1'b0;
    logic       set_orientation = 1'b0, set_key = 1'b0, key_en = 1'b0;
    logic       o_ready = 1'b1;
    logic [7:0] i_r = '0, i_g = '0, i_b = '0;
    logic [7:0] key_r = '0, key_g = '0, key_b = '0;
    logic [2:0] orientation = '0;
    logic       o_valid, o_last, o_transparent, busy;
    logic [7:0] o_r, o_g, o_b;

    sprite_xform_buffer #(.SIDE(8), .CW(8)) dut (
        .clk(clk), .rst(rst), .write(write), .i_valid(i_valid),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .read(read),
        .set_orientation(set_orientation), .orientation(orientation),
        .set_key(set_key), .key_en(key_en),
        .key_r(key_r), .key_g(key_g), .key_b(key_b),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_last(o_last),
        .o_transparent(o_transparent), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [23:0] mem_m [NN];
    logic [23:0] exp_pix [NN];
    logic [23:0] key_m = '0;
    bit          key_en_m = 1'b0;
    int          orient_m = 0;
    int          pos = 0;
    bit          active = 1'b0;
    int          rx_r [NN];
    bit          rx_t [NN];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Source pixel index for output index k, straight from the geometry.
    function automatic int src_of(input int k, input int ori);
        int r, c, sr, sc;
        r = k / N;
        c = k % N;
        case (ori % 4)
            0:       begin sr = r;         sc = c;         end
            1:       begin sr = N - 1 - c; sc = r;         end
            2:       begin sr = N - 1 - r; sc = N - 1 - c; end
            default: begin sr = c;         sc = N - 1 - r; end
        endcase
        if (ori >= 4) sc = N - 1 - sc;
        return sr * N + sc;
    endfunction

    function automatic logic [23:0] pix_of(input int i, input int variant);
        logic [7:0] a, g, b;
        a = i[7:0];
        g = (variant == 0) ? 8'd0 : 8'(i * 3);
        b = (variant == 0) ? 8'd0 : 8'(255 - i);
        return {a, g, b};
    endfunction

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (active) begin
                if (o_valid) begin
                    chk($sformatf("pix[%0d]", pos), int'({o_r, o_g, o_b}), int'(exp_pix[pos]));
                    chk($sformatf("last[%0d]", pos), int'(o_last), int'(pos == NN - 1));
                    chk($sformatf("transp[%0d]", pos), int'(o_transparent),
                        int'(key_en_m && (exp_pix[pos] == key_m)));
                    rx_r[pos] = int'(o_r);
                    rx_t[pos] = o_transparent;
                    if (o_ready) begin
                        pos++;
                        if (pos == NN) active = 1'b0;
                    end
                end
            end else begin
                chk("idle_valid", int'(o_valid), 0);
                chk("idle_transp", int'(o_transparent), 0);
            end
        end
    endtask

    task automatic do_load(input int variant, input bit toggle);
        int n = 0;
        int cyc = 0;
        write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        chk("load_busy_start", int'(busy), 1);
        while (n < NN && cyc < 500) begin
            i_valid = !toggle || (cyc % 2 == 0);
            {i_r, i_g, i_b} = i_valid ? pix_of(n, variant) : 24'hEEEEEE;
            @(posedge clk); #1;
            cyc++;
            if (i_valid) begin
                mem_m[n] = pix_of(n, variant);
                n++;
            end
            chk("load_busy", int'(busy), int'(n < NN));
        end
        i_valid = 1'b0;
        if (n < NN) chk("load_timeout", n, NN);
    endtask

    task automatic do_read(input int ori, input int stall_at, input int abort_at,
                           input int midset, input int exp_cyc);
        int cyc = 0;
        int stall_cnt = 0;
        bit stalled = 1'b0;
        if (ori >= 0) begin
            set_orientation = 1'b1;
            orientation = 3'(ori);
            @(posedge clk); #1;
            set_orientation = 1'b0;
            orient_m = ori;
        end
        for (int k = 0; k < NN; k++) begin
            exp_pix[k] = mem_m[src_of(k, orient_m)];
            rx_r[k] = -1;
            rx_t[k] = 1'b0;
        end
        pos = 0;
        active = 1'b1;
        read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) chk("first_valid", int'(o_valid), 1);
            if (midset >= 0) begin
                set_orientation = (cyc == midset);
                if (cyc == midset) begin
                    orientation = 3'd3;
                    orient_m = 3;
                end
            end
            if (abort_at >= 0 && pos == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_valid", int'(o_valid), 0);
                chk("abort_busy", int'(busy), 0);
                rst = 1'b0;
                orient_m = 0;
                key_en_m = 1'b0;
                key_m = '0;
                break;
            end
            if (stall_at >= 0 && pos == stall_at && !stalled) begin
                o_ready = 1'b0;
                stall_cnt = 3;
                stalled = 1'b1;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) o_ready = 1'b1;
            end
            if (!busy) break;
            if (cyc > 500) begin
                chk("read_timeout", cyc, exp_cyc);
                break;
            end
        end
        o_ready = 1'b1;
        set_orientation = 1'b0;
        if (exp_cyc > 0) chk("burst_cycles", cyc, exp_cyc);
    endtask

    task automatic do_set_key(input bit en, input logic [7:0] r);
        set_key = 1'b1;
        key_en = en;
        key_r = r;
        key_g = 8'd0;
        key_b = 8'd0;
        @(posedge clk); #1;
        set_key = 1'b0;
        key_en_m = en;
        key_m = {r, 8'd0, 8'd0};
    endtask

    function automatic int count_transp();
        int n = 0;
        for (int k = 0; k < NN; k++) n += int'(rx_t[k]);
        return n;
    endfunction

    initial begin
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pix", int'({o_r, o_g, o_b}), 0);
        chk("rst_last", int'(o_last), 0);
        chk("rst_transp", int'(o_transparent), 0);
        rst = 1'b0;

        do_load(0, 1'b0);
        // Pixels offered outside LOAD must not be stored.
        i_valid = 1'b1;
        {i_r, i_g, i_b} = 24'hFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        i_valid = 1'b0;

        do_read(0, -1, -1, -1, NN + 1);
        chk("o0_p0", rx_r[0], 0);
        chk("o0_p63", rx_r[63], 63);
        do_read(1, -1, -1, -1, NN + 1);
        chk("o1_p0", rx_r[0], 56);
        chk("o1_p1", rx_r[1], 48);
        do_read(2, -1, -1, -1, NN + 1);
        chk("o2_p0", rx_r[0], 63);
        do_read(3, -1, -1, -1, NN + 1);
        chk("o3_p0", rx_r[0], 7);
        do_read(4, -1, -1, -1, NN + 1);
        chk("o4_p0", rx_r[0], 7);
        chk("o4_p8", rx_r[8], 15);
        do_read(5, -1, -1, -1, NN + 1);
        chk("o5_p0", rx_r[0], 63);

        do_read(0, 5, -1, -1, NN + 4);
        chk("stall_p5", rx_r[5], 5);
        chk("stall_p6", rx_r[6], 6);

        do_set_key(1'b1, 8'd10);
        do_read(0, -1, -1, 20, NN + 1);
        chk("key_o0_idx10", int'(rx_t[10]), 1);
        chk("key_o0_count", count_transp(), 1);
        do_read(-1, -1, -1, -1, NN + 1);
        chk("midset_o3_p0", rx_r[0], 7);
        chk("key_o3_idx41", int'(rx_t[41]), 1);
        chk("key_o3_count", count_transp(), 1);
        do_set_key(1'b0, 8'd0);

        do_load(1, 1'b1);
        do_read(0, -1, -1, -1, NN + 1);
        chk("toggle_p37", rx_r[37], 37);

        do_read(0, -1, 20, -1, 0);
        repeat (2) @(posedge clk);
        #1;
        do_read(0, -1, -1, -1, NN + 1);
        chk("post_rst_p20", rx_r[20], 20);
        chk("post_rst_p63", rx_r[63], 63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
